// File: rtl/simd_pkg.sv
// rtl/simd_pkg.sv - shared SIMD lane defaults, accumulator FSM state and packed-lane type
//
// Holds the lane geometry shared with the SIMD adder stage, the state encoding
// of the lane accumulator frame FSM, and a packed-lane view of the adder bus.
package simd_pkg;

    localparam int LANES_DEF  = 4;
    localparam int LANE_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_e;

    // Packed view of the adder output: element i is byte lane i.
    typedef logic [LANES_DEF-1:0][LANE_W_DEF-1:0] lane_vec_t;

endpackage

// File: rtl/simd_lane_acc.sv
// rtl/simd_lane_acc.sv - one lane accumulator with sticky overflow and wrap/saturate adder
//
// Optional build macro: SIMD_ACC_SAT_EN (saturating accumulate; wrap when undefined).
//
// Ports:
//   clk      input   clock, rising edge
//   reset    input   asynchronous active-high reset
//   clr_i    input   synchronous clear of accumulator and overflow flag
//   add_en_i input   add lane_i into the accumulator this cycle
//   lane_i   input   LANE_W-bit lane value, zero-extended before the add
//   acc_o    output  ACC_W-bit registered accumulator
//   ovf_o    output  sticky overflow flag for the current frame
module simd_lane_acc
    import simd_pkg::*;
#(
    parameter int LANE_W = LANE_W_DEF,
    parameter int ACC_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              add_en_i,
    input  logic [LANE_W-1:0] lane_i,
    output logic [ACC_W-1:0]  acc_o,
    output logic              ovf_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W:0]   sum;

    // One extra bit so the carry out of the accumulator is observable.
    assign sum = {1'b0, acc_q} + {{(ACC_W + 1 - LANE_W){1'b0}}, lane_i};

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (add_en_i) begin
`ifdef SIMD_ACC_SAT_EN
            // Clamp at all-ones; once clamped any further non-zero add carries
            // again, so the lane stays pinned at all-ones.
            acc_d = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
            acc_d = sum[ACC_W-1:0];
`endif
            ovf_d = ovf_q | sum[ACC_W];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc_o = acc_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/simd_lane_accumulator.sv
// rtl/simd_lane_accumulator.sv - per-lane frame accumulator behind the packed SIMD adder
//
// Optional build macro: SIMD_ACC_SAT_EN (saturating lane accumulate; wrap when undefined).
//
// Ports:
//   clk        input   clock, rising edge
//   reset      input   asynchronous active-high reset, clears all state
//   clear      input   synchronous frame abort, priority over all but reset
//   in_valid   input   in_sum holds a beat
//   in_ready   output  block can accept a beat
//   in_sum     input   LANES*LANE_W packed lane sums, lane i at [i*LANE_W +: LANE_W]
//   out_valid  output  out_acc/out_ovf hold a completed frame
//   out_ready  input   consumer takes the frame
//   out_acc    output  LANES*ACC_W packed accumulators, lane i at [i*ACC_W +: ACC_W]
//   out_ovf    output  LANES sticky per-lane overflow flags
module simd_lane_accumulator
    import simd_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int LANE_W = LANE_W_DEF,
    parameter int ACC_W  = 16,   // must exceed LANE_W
    parameter int BEATS  = 4     // must be at least 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*LANE_W-1:0] in_sum,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*ACC_W-1:0]  out_acc,
    output logic [LANES-1:0]        out_ovf
);

    localparam int               CNT_W    = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    acc_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             out_valid_q;
    logic             in_ready_q;

    logic accept;
    logic handshake;
    logic lane_clr;

    // A beat in the clear cycle is dropped; in_ready_q is low in DONE, so no
    // beat can slip in during the output handshake.
    assign accept    = in_valid && in_ready_q && !clear;
    assign handshake = out_valid_q && out_ready;
    assign lane_clr  = clear || handshake;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else if (clear) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_CNT) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        cnt_q       <= '0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= '0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        simd_lane_acc #(
            .LANE_W (LANE_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .clr_i    (lane_clr),
            .add_en_i (accept),
            .lane_i   (in_sum[i*LANE_W +: LANE_W]),
            .acc_o    (out_acc[i*ACC_W +: ACC_W]),
            .ovf_o    (out_ovf[i])
        );
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_simd_lane_accumulator.sv
// tb/tb_simd_lane_accumulator.sv - directed self-checking bench for simd_lane_accumulator
module tb_simd_lane_accumulator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    // Instance A: default geometry.
    logic        a_clear = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
    logic [31:0] a_in_sum = '0;
    logic        a_in_ready, a_out_valid;
    logic [63:0] a_out_acc;
    logic [3:0]  a_out_ovf;

    // Instance B: ACC_W=10, BEATS=5 for overflow behaviour.
    logic        b_clear = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic [31:0] b_in_sum = '0;
    logic        b_in_ready, b_out_valid;
    logic [39:0] b_out_acc;
    logic [3:0]  b_out_ovf;

    int tests_run = 0;
    int tests_failed = 0;

`ifdef SIMD_ACC_SAT_EN
    localparam logic [39:0] B_EXP_ACC = {4{10'h3FF}};
`else
    localparam logic [39:0] B_EXP_ACC = {4{10'h0FB}};
`endif

    always #5 clk = ~clk;

    simd_lane_accumulator u_dut_a (
        .clk(clk), .reset(reset), .clear(a_clear),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sum(a_in_sum),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_acc(a_out_acc), .out_ovf(a_out_ovf)
    );

    simd_lane_accumulator #(.ACC_W(10), .BEATS(5)) u_dut_b (
        .clk(clk), .reset(reset), .clear(b_clear),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sum(b_in_sum),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_acc(b_out_acc), .out_ovf(b_out_ovf)
    );

    task automatic do_reset();
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        a_clear = 1'b0;    b_clear = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++; if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %0b want 0", a_out_valid); end
        tests_run++; if (a_in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %0b want 1", a_in_ready); end
        tests_run++; if (a_out_acc !== 64'h0) begin tests_failed++; $display("FAIL reset_out_acc: got %h want 0", a_out_acc); end
        tests_run++; if (a_out_ovf !== 4'h0) begin tests_failed++; $display("FAIL reset_out_ovf: got %h want 0", a_out_ovf); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        a_out_ready = 1'b1;
        a_in_sum = 32'h01020304;
        a_in_valid = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++; if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_early_valid: got %0b want 0", a_out_valid); end
        @(negedge clk);
        a_in_valid = 1'b0;
        tests_run++; if (a_out_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_valid: got %0b want 1", a_out_valid); end
        tests_run++; if (a_out_acc !== 64'h0004_0008_000C_0010) begin tests_failed++; $display("FAIL basic_acc: got %h want 0004_0008_000c_0010", a_out_acc); end
        tests_run++; if (a_out_ovf !== 4'h0) begin tests_failed++; $display("FAIL basic_ovf: got %h want 0", a_out_ovf); end
        tests_run++; if (a_in_ready !== 1'b0) begin tests_failed++; $display("FAIL basic_ready_done: got %0b want 0", a_in_ready); end
        @(negedge clk);
        tests_run++; if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_valid_after: got %0b want 0", a_out_valid); end
        tests_run++; if (a_in_ready !== 1'b1) begin tests_failed++; $display("FAIL basic_ready_after: got %0b want 1", a_in_ready); end
        tests_run++; if (a_out_acc !== 64'h0) begin tests_failed++; $display("FAIL basic_acc_after: got %h want 0", a_out_acc); end
    endtask

    task automatic test_overflow();
        b_out_ready = 1'b0;
        b_in_sum = 32'hFFFFFFFF;
        b_in_valid = 1'b1;
        repeat (5) @(negedge clk);
        b_in_valid = 1'b0;
        tests_run++; if (b_out_valid !== 1'b1) begin tests_failed++; $display("FAIL ovf_valid: got %0b want 1", b_out_valid); end
        tests_run++; if (b_out_acc !== B_EXP_ACC) begin tests_failed++; $display("FAIL ovf_acc: got %h want %h", b_out_acc, B_EXP_ACC); end
        tests_run++; if (b_out_ovf !== 4'hF) begin tests_failed++; $display("FAIL ovf_flags: got %h want f", b_out_ovf); end
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
        tests_run++; if (b_out_ovf !== 4'h0) begin tests_failed++; $display("FAIL ovf_flags_cleared: got %h want 0", b_out_ovf); end
        tests_run++; if (b_out_acc !== 40'h0) begin tests_failed++; $display("FAIL ovf_acc_cleared: got %h want 0", b_out_acc); end
    endtask

    task automatic test_stall();
        a_out_ready = 1'b0;
        a_in_sum = 32'h01010101;
        a_in_valid = 1'b1;
        repeat (4) @(negedge clk);
        a_in_sum = 32'h10101010;
        for (int i = 0; i < 3; i++) begin
            tests_run++; if (a_out_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_valid[%0d]: got %0b want 1", i, a_out_valid); end
            tests_run++; if (a_out_acc !== {4{16'h0004}}) begin tests_failed++; $display("FAIL stall_acc[%0d]: got %h want 0004 per lane", i, a_out_acc); end
            tests_run++; if (a_in_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_ready[%0d]: got %0b want 0", i, a_in_ready); end
            @(negedge clk);
        end
        a_out_ready = 1'b1;
        @(negedge clk);
        tests_run++; if (a_out_acc !== 64'h0) begin tests_failed++; $display("FAIL stall_hs_acc: got %h want 0", a_out_acc); end
        tests_run++; if (a_in_ready !== 1'b1) begin tests_failed++; $display("FAIL stall_hs_ready: got %0b want 1", a_in_ready); end
        @(negedge clk);
        a_in_valid = 1'b0;
        tests_run++; if (a_out_acc !== {4{16'h0010}}) begin tests_failed++; $display("FAIL stall_newframe_acc: got %h want 0010 per lane", a_out_acc); end
        tests_run++; if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_newframe_valid: got %0b want 0", a_out_valid); end
    endtask

    task automatic test_clear();
        a_out_ready = 1'b1;
        a_in_sum = 32'h01010101;
        a_in_valid = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++; if (a_out_acc !== {4{16'h0002}}) begin tests_failed++; $display("FAIL clear_pre_acc: got %h want 0002 per lane", a_out_acc); end
        a_in_sum = 32'h05050505;
        a_clear = 1'b1;
        @(negedge clk);
        a_clear = 1'b0;
        a_in_sum = 32'h01010101;
        tests_run++; if (a_out_acc !== 64'h0) begin tests_failed++; $display("FAIL clear_acc: got %h want 0", a_out_acc); end
        tests_run++; if (a_in_ready !== 1'b1) begin tests_failed++; $display("FAIL clear_ready: got %0b want 1", a_in_ready); end
        repeat (3) @(negedge clk);
        tests_run++; if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL clear_count_restart: got %0b want 0", a_out_valid); end
        @(negedge clk);
        a_in_valid = 1'b0;
        tests_run++; if (a_out_valid !== 1'b1) begin tests_failed++; $display("FAIL clear_frame_valid: got %0b want 1", a_out_valid); end
        tests_run++; if (a_out_acc !== {4{16'h0004}}) begin tests_failed++; $display("FAIL clear_frame_acc: got %h want 0004 per lane", a_out_acc); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        a_out_ready = 1'b0;
        b_out_ready = 1'b0;
        a_in_sum = 32'h01020304;
        b_in_sum = 32'hFFFFFFFF;
        a_in_valid = 1'b1;
        b_in_valid = 1'b1;
        repeat (4) @(negedge clk);
        a_in_valid = 1'b0;
        @(negedge clk);
        b_in_valid = 1'b0;
        tests_run++; if (a_out_valid !== 1'b1) begin tests_failed++; $display("FAIL areset_pre_a: got %0b want 1", a_out_valid); end
        tests_run++; if (b_out_ovf !== 4'hF) begin tests_failed++; $display("FAIL areset_pre_b_ovf: got %h want f", b_out_ovf); end
        #1 reset = 1'b1;
        #1;
        tests_run++; if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL areset_valid: got %0b want 0", a_out_valid); end
        tests_run++; if (a_out_acc !== 64'h0) begin tests_failed++; $display("FAIL areset_acc: got %h want 0", a_out_acc); end
        tests_run++; if (b_out_valid !== 1'b0) begin tests_failed++; $display("FAIL areset_b_valid: got %0b want 0", b_out_valid); end
        tests_run++; if (b_out_acc !== 40'h0) begin tests_failed++; $display("FAIL areset_b_acc: got %h want 0", b_out_acc); end
        tests_run++; if (b_out_ovf !== 4'h0) begin tests_failed++; $display("FAIL areset_b_ovf: got %h want 0", b_out_ovf); end
        #1 reset = 1'b0;
        @(negedge clk);
        tests_run++; if (a_in_ready !== 1'b1) begin tests_failed++; $display("FAIL areset_ready: got %0b want 1", a_in_ready); end
        tests_run++; if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL areset_valid_after: got %0b want 0", a_out_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        do_reset();
        test_overflow();
        do_reset();
        test_stall();
        do_reset();
        test_clear();
        do_reset();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
